seq_restoring_divider: RTL and testbench

//   Multi-cycle unsigned integer divider built on repeated trial subtraction, one quotient bit per clock.

---
 rtl/seq_restoring_divider.sv | 153 +++++++++++++++
 tb/tb_seq_restoring_divider.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (one extra cycle).
module seq_restoring_divider #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef DIV_SIGNED_EN
    // last CALC cycle is the sign-correction step
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    count;

    logic             accept;
    logic             dvs_zero;
    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] p_it;
    logic [WIDTH-1:0] q_it;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] dz_quot;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
`endif

    assign accept   = start && (state != CALC);
    assign dvs_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
    assign a_mag   = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag   = divisor[WIDTH-1] ? -divisor : divisor;
    assign dz_quot = dividend[WIDTH-1] ? WIDTH'(1) : '1;
`else
    assign a_mag   = dividend;
    assign b_mag   = divisor;
    assign dz_quot = '1;
`endif

    // one restoring step: shift in next dividend bit, trial-subtract
    always_comb begin
        p_sh   = {p_q, q_q[WIDTH-1]};
        trial  = p_sh - {1'b0, dvs_q};
        borrow = trial[WIDTH];
        p_it   = borrow ? p_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        q_it   = {q_q[WIDTH-2:0], ~borrow};
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = dvs_zero ? DONE : CALC;
            CALC: if (count == LAST) state_nxt = DONE;
            DONE: begin
                if (start) state_nxt = dvs_zero ? DONE : CALC;
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // handshake outputs decoded from state
    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // operand capture, iteration and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else if (accept) begin
            p_q         <= '0;
            q_q         <= a_mag;
            dvs_q       <= b_mag;
            count       <= '0;
            div_by_zero <= dvs_zero;
`ifdef DIV_SIGNED_EN
            neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r       <= dividend[WIDTH-1];
`endif
            if (dvs_zero) begin
                quotient  <= dz_quot;
                remainder <= dividend;
            end
        end else if (state == CALC) begin
            count <= count + CW'(1);
`ifdef DIV_SIGNED_EN
            if (count == LAST) begin
                quotient  <= neg_q ? -q_q : q_q;
                remainder <= neg_r ? -p_q : p_q;
            end else begin
                p_q <= p_it;
                q_q <= q_it;
            end
`else
            p_q <= p_it;
            q_q <= q_it;
            if (count == LAST) begin
                quotient  <= q_it;
                remainder <= p_it;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed-vector bench for seq_restoring_divider.
// Results checked against hand-computed quotient/remainder.
module tb_seq_restoring_divider;

    localparam int W = 7;
`ifdef DIV_SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int a, input int b);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int nbusy, output int lat);
        nbusy = 0;
        lat   = lat0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            step();
            lat++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_div(input string tag, input int a, input int b,
                           input int eq, input int er, input int edz);
        int nb, lat;
        launch(a, b);
        wait_done(1, nb, lat);
        check({tag, "_lat"}, lat, edz ? 1 : LAT);
        check({tag, "_busy"}, nb, edz ? 0 : LAT - 1);
        check({tag, "_q"}, int'(quotient), eq);
        check({tag, "_r"}, int'(remainder), er);
        check({tag, "_dbz"}, int'(div_by_zero), edz);
    endtask

    initial begin
        int nb, lat;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(quotient), 0);
        check("rst_r", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        step();
        step();
        reset = 1'b0;
        step();

`ifdef DIV_SIGNED_EN
        run_div("s1", -50, 7, 121, 127, 0);
        step();
        run_div("s2", 50, -7, 121, 1, 0);
        step();
        run_div("s3", -64, -1, 64, 0, 0);
        step();
        run_div("s4", 5, 0, 127, 5, 1);
        step();
        run_div("s5", -5, 0, 1, 123, 1);
        step();
        run_div("s6", 20, 6, 3, 2, 0);
`else
        run_div("t1", 100, 7, 14, 2, 0);
        step();
        check("t1_pulse", int'(done), 0);
        check("t1_hold_q", int'(quotient), 14);
        check("t1_hold_r", int'(remainder), 2);

        run_div("t2a", 127, 1, 127, 0, 0);
        run_div("t2b", 3, 10, 0, 3, 0);
        step();
        check("t2_pulse", int'(done), 0);

        run_div("t3", 5, 0, 127, 5, 1);
        step();
        check("t3_pulse", int'(done), 0);
        check("t3_busy", int'(busy), 0);
        check("t3_hold_dbz", int'(div_by_zero), 1);

        run_div("t3z", 0, 5, 0, 0, 0);
        step();

        launch(100, 7);
        step();
        step();
        start    = 1'b1;
        dividend = 7'd9;
        divisor  = 7'd3;
        step();
        start = 1'b0;
        wait_done(4, nb, lat);
        check("t4_lat", lat, LAT);
        check("t4_q", int'(quotient), 14);
        check("t4_r", int'(remainder), 2);
        step();
        check("t4_pulse", int'(done), 0);

        launch(100, 7);
        step();
        step();
        step();
        check("t5_busy_pre", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("t5_busy", int'(busy), 0);
        check("t5_done", int'(done), 0);
        check("t5_q", int'(quotient), 0);
        check("t5_r", int'(remainder), 0);
        step();
        reset = 1'b0;
        step();
        run_div("t5b", 20, 6, 3, 2, 0);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
